// File: rtl/mux_2bit_pkg.sv
// Shared defaults for the mux_2bit block: data/counter widths and the
// saturation ceiling used by the optional sel-transition counter.
package mux_2bit_pkg;

    localparam int unsigned MuxWidthDefault = 2;
    localparam int unsigned CntWidthDefault = 8;

    // Counter widths up to CntWidthMax take their all-ones ceiling from this constant.
    localparam int unsigned                  CntWidthMax  = 32;
    localparam logic [CntWidthMax-1:0]       CntSatMaxAll = '1;

endpackage

// File: rtl/mux2_slice.sv
// One-bit 2:1 select cell; the conditional operator keeps standard X-merge
// behaviour when s is unknown.
module mux2_slice (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    always_comb begin
        y = s ? b : a;
    end

endmodule

// File: rtl/mux_2bit.sv
// WIDTH-bit 2:1 mux with registered copies of the result and the select.
// Define MUX_2BIT_STATS_EN to add the saturating sel_changes transition counter.
module mux_2bit
    import mux_2bit_pkg::*;
#(
    parameter int unsigned WIDTH = MuxWidthDefault,
    parameter int unsigned CNT_W = CntWidthDefault
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
`ifdef MUX_2BIT_STATS_EN
    ,
    output logic [CNT_W-1:0] sel_changes
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        mux2_slice u_slice (
            .a (in0[i]),
            .b (in1[i]),
            .s (sel),
            .y (out[i])
        );
    end

    logic [WIDTH-1:0] out_d;
    logic             sel_d;

    always_comb begin
        out_d = out;
        sel_d = sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            sel_q <= 1'b0;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
        end
    end

`ifdef MUX_2BIT_STATS_EN
    localparam logic [CNT_W-1:0] SatMax = CntSatMaxAll[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A transition is sel differing from last edge's sample; hold at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if ((sel != sel_q) && (cnt_q != SatMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sel_changes = cnt_q;
`endif

endmodule

// File: tb/tb_mux_2bit.sv
// Directed, table-driven bench for mux_2bit; counter checks compile in
// only when MUX_2BIT_STATS_EN is defined.
module tb_mux_2bit;

    logic [1:0] in0, in1, out, out_q;
    logic       sel, sel_q, clk, rst;
`ifdef MUX_2BIT_STATS_EN
    logic [7:0] sel_changes;
`endif

    int checks = 0;
    int errors = 0;

    mux_2bit #(
        .WIDTH (2),
        .CNT_W (8)
    ) dut (
        .in0         (in0),
        .in1         (in1),
        .sel         (sel),
        .out         (out),
        .clk         (clk),
        .rst         (rst),
        .out_q       (out_q),
        .sel_q       (sel_q)
`ifdef MUX_2BIT_STATS_EN
        ,
        .sel_changes (sel_changes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] in0;
        logic [1:0] in1;
        logic       sel;
        logic [1:0] exp_out;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Inputs change just after negedge; outputs are sampled 1ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{2'b00, 2'b01, 1'b1, 2'b01};
        vecs[1] = '{2'b00, 2'b10, 1'b1, 2'b10};
        vecs[2] = '{2'b01, 2'b11, 1'b1, 2'b11};
        vecs[3] = '{2'b01, 2'b00, 1'b1, 2'b00};
        vecs[4] = '{2'b01, 2'b01, 1'b0, 2'b01};
        vecs[5] = '{2'b00, 2'b01, 1'b0, 2'b00};
        vecs[6] = '{2'b10, 2'b11, 1'b0, 2'b10};
        vecs[7] = '{2'b01, 2'b11, 1'b0, 2'b01};

        rst = 1'b1;
        in0 = 2'b11;
        in1 = 2'b10;
        sel = 1'b1;
        tick();
        check("reset_out_q", 32'(out_q), 32'h0);
        check("reset_sel_q", 32'(sel_q), 32'h0);
        check("out_during_rst", 32'(out), 32'h2);
`ifdef MUX_2BIT_STATS_EN
        check("reset_cnt", 32'(sel_changes), 32'h0);
`endif

        // Reset edge then first loaded value.
        in0 = 2'b10;
        in1 = 2'b01;
        sel = 1'b0;
        tick();
        check("rst_edge_out_q", 32'(out_q), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_out_q", 32'(out_q), 32'h2);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in0 = vecs[i].in0;
            in1 = vecs[i].in1;
            sel = vecs[i].sel;
            #1;
            check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            tick();
            check($sformatf("vec%0d_out_q", i), 32'(out_q), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_sel_q", i), 32'(sel_q), 32'(vecs[i].sel));
        end

        // Mid-operation reset clears registers while out stays combinational.
        @(negedge clk);
        in0 = 2'b01;
        in1 = 2'b11;
        sel = 1'b1;
        tick();
        check("pre_mid_rst_out_q", 32'(out_q), 32'h3);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("mid_rst_out_q", 32'(out_q), 32'h0);
        check("mid_rst_sel_q", 32'(sel_q), 32'h0);
        check("mid_rst_out", 32'(out), 32'h3);
        @(negedge clk);
        rst = 1'b0;

`ifdef MUX_2BIT_STATS_EN
        // sel_q is 0 from reset; sel was held at 1 through reset, so start clean.
        sel = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sel = ~sel;
        end
        tick();
        check("cnt_five", 32'(sel_changes), 32'd5);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sel = ~sel;
        end
        tick();
        check("cnt_saturated", 32'(sel_changes), 32'd255);
        @(negedge clk);
        sel = ~sel;
        tick();
        check("cnt_no_wrap", 32'(sel_changes), 32'd255);

        // Reset coincident with a sel toggle: reset wins.
        @(negedge clk);
        sel = ~sel_q;
        rst = 1'b1;
        tick();
        check("rst_vs_toggle_cnt", 32'(sel_changes), 32'd0);
        check("rst_vs_toggle_sel_q", 32'(sel_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        tick();
        check("cnt_after_rst", 32'(sel_changes), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_2bit.md
MUX_2BIT -- requirements
Module: mux_2bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the data width of in0, in1, out and out_q.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of sel_changes.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset, synchronous and active-high.
REQ-005 The block SHALL have port in0, input, WIDTH bits, data selected when sel=0.
REQ-006 The block SHALL have port in1, input, WIDTH bits, data selected when sel=1.
REQ-007 The block SHALL have port sel, input, 1 bit, the select.
REQ-008 The block SHALL have port out, output, WIDTH bits, the combinational mux result.
REQ-009 The block SHALL have port out_q, output, WIDTH bits, out registered by one clock.
REQ-010 The block SHALL have port sel_q, output, 1 bit, sel registered by one clock.
REQ-011 The block SHALL have port sel_changes, output, CNT_W bits, a saturating count of sel transitions (present only with the statistics macro).
REQ-012 Port order SHALL be in0, in1, sel, out, then clk, rst, out_q, sel_q, sel_changes, so that positional instantiation with four signals stays valid.

Function
REQ-013 out SHALL equal in1 when sel=1, else in0, purely combinational with zero latency and no dependence on clk or rst.
REQ-014 If sel is X/Z, out SHALL be in0 where in0 equals in1 bitwise, else X (standard conditional-operator semantics).
REQ-015 out_q SHALL load out on every rising clk edge when rst=0 (one-cycle latency).
REQ-016 sel_q SHALL load sel on every rising clk edge when rst=0.
REQ-017 sel_changes SHALL increment by 1 on each edge where sel differs from sel_q and rst=0.
REQ-018 sel_changes SHALL saturate at all-ones and never wrap.
REQ-019 When rst and a sel change coincide on the same edge, reset SHALL win.

Reset
REQ-020 On a rising clk edge with rst=1, out_q SHALL become 0, sel_q 0 and sel_changes 0.
REQ-021 out SHALL remain combinational and unaffected by rst.
REQ-022 Reset asserted mid-operation SHALL clear the registers on the next edge with no other side effect.

Configuration
REQ-023 Macro MUX_2BIT_STATS_EN SHALL control the statistics feature.
REQ-024 With MUX_2BIT_STATS_EN defined, the sel_changes port and its counter SHALL exist.
REQ-025 Without MUX_2BIT_STATS_EN, the port and counter SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package mux_2bit_pkg SHALL hold the WIDTH and CNT_W defaults and the saturating-max constant.
REQ-027 Per-bit selection SHALL be built from WIDTH instances of sub-module mux2_slice (1-bit a, b, s -> y).

Verification
REQ-028 With in0=00, in1=01, sel=1, out SHALL be 01; with in0=00, in1=10, sel=1, out SHALL be 10; with in0=01, in1=11, sel=1, out SHALL be 11; with in0=01, in1=00, sel=1, out SHALL be 00.
REQ-029 With in0=01, in1=01, sel=0, out SHALL be 01; with in0=00, in1=01, sel=0, out SHALL be 00; with in0=10, in1=11, sel=0, out SHALL be 10; with in0=01, in1=11, sel=0, out SHALL be 01.
REQ-030 With rst=1 for one edge then in0=10, in1=01, sel=0, out_q SHALL be 00 after the reset edge and 10 after the next edge.
REQ-031 Toggling sel every cycle for 300 cycles (stats enabled) SHALL leave sel_changes at 255, saturated.
REQ-032 Asserting rst on the same edge as a sel toggle SHALL leave sel_changes=0 and sel_q=0.
REQ-033 Compiling without MUX_2BIT_STATS_EN SHALL pass REQ-028..REQ-030 unchanged, with no sel_changes port present.
